// File: rtl/rr_fifo_merge_pkg.sv
// Shared definitions for the round-robin FIFO merge.
//   lock_state_t : burst-lock state (IDLE=0, LOCKED=1), used when RR_MERGE_LOCK_EN is defined
//   MAX_NREQ     : largest supported requester count
//   rr_next      : round-robin successor of a requester index, wrapping at n
package rr_merge_pkg;

    localparam int MAX_NREQ = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_fifo_merge_if.sv
// Handshake bundle between the requesters, the merge block and the consumer.
//   REQ_VALID/REQ_DATA/REQ_LAST : per-requester beat (requester i at REQ_DATA[i*WIDTH +: WIDTH])
//   REQ_READY                   : per-requester accept, at most one bit set
//   OUT_VALID/DATA/LAST/ID      : head of the merge buffer
//   OUT_READY                   : consumer dequeue
// Modports: master = requester/consumer side, slave = merge block.
interface rr_fifo_merge_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = $clog2(NREQ)
) ();

    logic [NREQ-1:0]       REQ_VALID;
    logic [NREQ*WIDTH-1:0] REQ_DATA;
    logic [NREQ-1:0]       REQ_LAST;
    logic [NREQ-1:0]       REQ_READY;
    logic                  OUT_VALID;
    logic [WIDTH-1:0]      OUT_DATA;
    logic                  OUT_LAST;
    logic [IDW-1:0]        OUT_ID;
    logic                  OUT_READY;

    modport master (
        output REQ_VALID, REQ_DATA, REQ_LAST, OUT_READY,
        input  REQ_READY, OUT_VALID, OUT_DATA, OUT_LAST, OUT_ID
    );

    modport slave (
        input  REQ_VALID, REQ_DATA, REQ_LAST, OUT_READY,
        output REQ_READY, OUT_VALID, OUT_DATA, OUT_LAST, OUT_ID
    );

endinterface

// File: rtl/rr_fifo_merge_buf.sv
// rr_merge_buf: 2-entry FIFO used as the merge output buffer.
//   CLK, RST  : clock, synchronous active-high reset (clears pointers and count only)
//   enq       : write enq_data (ignored when full)
//   deq       : pop the head entry (ignored when empty)
//   deq_data  : head entry, don't-care when empty
//   full_n    : not full
//   empty_n   : not empty
module rr_merge_buf #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq,
    output logic [WIDTH-1:0] deq_data,
    output logic             full_n,
    output logic             empty_n
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_enq;
    logic             do_deq;

    assign full_n   = (count != 2'd2);
    assign empty_n  = (count != 2'd0);
    assign do_enq   = enq && full_n;
    assign do_deq   = deq && empty_n;
    assign deq_data = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_enq) wr_ptr <= ~wr_ptr;
            if (do_deq) rd_ptr <= ~rd_ptr;
            case ({do_enq, do_deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset.
    always_ff @(posedge CLK) begin
        if (do_enq) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/rr_fifo_merge.sv
// rr_fifo_merge: round-robin merge of NREQ requesters into one 2-entry buffered stream.
//   CLK  : clock
//   RST  : synchronous active-high reset
//   bus  : rr_fifo_merge_if.slave (requester beats in, merged {ID, LAST, DATA} stream out)
// Optional feature, macro RR_MERGE_LOCK_EN: once a beat with REQ_LAST=0 is accepted, the
// grant stays with that requester until its REQ_LAST=1 beat is accepted.
//
//   state  | meaning
//   IDLE   | per-beat round-robin among all valid requesters
//   LOCKED | only the recorded owner is eligible; PRI held at owner+1
module rr_fifo_merge
    import rr_merge_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic           CLK,
    input  logic           RST,
    rr_fifo_merge_if.slave bus
);

    localparam int EW = WIDTH + IDW + 1;

    logic [IDW-1:0]   pri_q;
    logic [IDW-1:0]   pri_d;
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  win_mask;
    logic             found;
    logic [IDW-1:0]   win;
    int               scan;
    logic             accept;
    logic             acc_last;
    logic [WIDTH-1:0] acc_data;
    logic             full_n;
    logic             empty_n;
    logic [EW-1:0]    enq_data;
    logic [EW-1:0]    deq_data;

`ifdef RR_MERGE_LOCK_EN
    lock_state_t    lock_q;
    lock_state_t    lock_d;
    logic [IDW-1:0] owner_q;
    logic [IDW-1:0] owner_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            lock_q  <= IDLE;
            owner_q <= '0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        case (lock_q)
            IDLE: begin
                if (accept && !acc_last) begin
                    lock_d  = LOCKED;
                    owner_d = win;
                end
            end
            LOCKED: begin
                if (accept && acc_last) lock_d = IDLE;
            end
        endcase
    end

    assign elig = (lock_q == LOCKED) ? (bus.REQ_VALID & (NREQ'(1) << owner_q))
                                     : bus.REQ_VALID;
`else
    assign elig = bus.REQ_VALID;
`endif

    // Scan from PRI upward, wrapping at NREQ; the first eligible requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan = int'(pri_q) + k;
            if (scan >= NREQ) scan = scan - NREQ;
            if (!found && |(elig & (NREQ'(1) << scan))) begin
                found = 1'b1;
                win   = IDW'(scan);
            end
        end
    end

    // Ready depends on buffer occupancy only, never on OUT_READY, so a full buffer
    // refuses a beat even when the head is leaving in the same cycle.
    assign win_mask      = NREQ'(1) << win;
    assign grant         = (found && full_n && !RST) ? win_mask : '0;
    assign bus.REQ_READY = grant;
    assign accept        = |(grant & bus.REQ_VALID);
    assign acc_last      = |(bus.REQ_LAST & win_mask);
    assign acc_data      = WIDTH'(bus.REQ_DATA >> (int'(win) * WIDTH));
    assign enq_data      = {win, acc_last, acc_data};

    // While locked the winner is always the owner, so reloading owner+1 leaves PRI unchanged.
    assign pri_d = accept ? IDW'(rr_next(int'(win), NREQ)) : pri_q;

    always_ff @(posedge CLK) begin
        if (RST) pri_q <= '0;
        else     pri_q <= pri_d;
    end

    rr_merge_buf #(
        .WIDTH(EW)
    ) u_buf (
        .CLK      (CLK),
        .RST      (RST),
        .enq      (accept),
        .enq_data (enq_data),
        .deq      (bus.OUT_READY),
        .deq_data (deq_data),
        .full_n   (full_n),
        .empty_n  (empty_n)
    );

    assign bus.OUT_VALID = empty_n;
    assign {bus.OUT_ID, bus.OUT_LAST, bus.OUT_DATA} = deq_data;

endmodule
